// File: rtl/output_mux_safe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | output_mux_safe                                                            |
// | Per-line bus mux whose selection only switches once both sources have been |
// | idle for IDLE_CYCLES cycles, or when forced. Define                        |
// | OUTPUT_MUX_SAFE_TIMEOUT_EN to also switch after TIMEOUT_CYCLES of waiting. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module output_mux_safe #(
  parameter int               WIDTH          = 4,
  parameter logic [WIDTH-1:0] IDLE_LEVEL     = '1,
  parameter int               IDLE_CYCLES    = 8,
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_line0,
  input  logic [WIDTH-1:0] in_line1,
  input  logic [WIDTH-1:0] select_line,
  input  logic [WIDTH-1:0] force_line,
  output logic [WIDTH-1:0] out_line,
  output logic [WIDTH-1:0] active_sel,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] switched,
  output logic [WIDTH-1:0] timeout
);

  localparam int              C_IW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [C_IW-1:0] C_IDLE_MAX = C_IW'(IDLE_CYCLES);
  localparam logic [C_IW-1:0] C_IDLE_THR = C_IW'(IDLE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      logic            w_idle_now;
      logic            w_idle_ok;
      logic            w_pend;
      logic            w_to_hit;
      logic            w_switch;
      logic [C_IW-1:0] r_icnt;
      logic            r_active;
      logic            r_switched;
      logic            r_timeout;

      assign w_idle_now = (in_line0[gi] == IDLE_LEVEL[gi]) &&
                          (in_line1[gi] == IDLE_LEVEL[gi]);
      // r_icnt counts previous idle cycles, so this cycle is the IDLE_CYCLES-th
      assign w_idle_ok  = w_idle_now && (r_icnt >= C_IDLE_THR);
      assign w_pend     = select_line[gi] != r_active;
      assign w_switch   = w_pend && (w_idle_ok || force_line[gi] || w_to_hit);

`ifdef OUTPUT_MUX_SAFE_TIMEOUT_EN
      localparam int              C_TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT_CYCLES - 1);
      logic [C_TW-1:0] r_wcnt;

      assign w_to_hit = w_pend && (r_wcnt == C_TO_LAST);

      // Restart on a switch too, so an immediate new request waits a full period
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          r_wcnt <= '0;
        end else if (!w_pend || w_switch) begin
          r_wcnt <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
`else
      assign w_to_hit = 1'b0;
`endif

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          r_icnt     <= '0;
          r_active   <= 1'b0;
          r_switched <= 1'b0;
          r_timeout  <= 1'b0;
        end else begin
          if (!w_idle_now) begin
            r_icnt <= '0;
          end else if (r_icnt != C_IDLE_MAX) begin
            r_icnt <= r_icnt + 1'b1;
          end
          if (w_switch) begin
            r_active <= select_line[gi];
          end
          r_switched <= w_switch;
          r_timeout  <= w_switch && w_to_hit && !w_idle_ok && !force_line[gi];
        end
      end

      assign out_line[gi]   = r_active ? in_line1[gi] : in_line0[gi];
      assign active_sel[gi] = r_active;
      assign pending[gi]    = w_pend;
      assign switched[gi]   = r_switched;
      assign timeout[gi]    = r_timeout;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_output_mux_safe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_output_mux_safe                                                         |
// | Directed and randomized bench for output_mux_safe with a behavioural model.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_output_mux_safe;

  localparam int         C_IDLE = 8;
  localparam int         C_TO   = 16;
  localparam logic [3:0] C_IL   = 4'hF;
`ifdef OUTPUT_MUX_SAFE_TIMEOUT_EN
  localparam bit C_TO_EN = 1'b1;
`else
  localparam bit C_TO_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] in_line0, in_line1, select_line, force_line;
  logic [3:0] out_line, active_sel, pending, switched, timeout;

  output_mux_safe #(
    .WIDTH(4), .IDLE_LEVEL(C_IL), .IDLE_CYCLES(C_IDLE), .TIMEOUT_CYCLES(C_TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_line0(in_line0), .in_line1(in_line1),
    .select_line(select_line), .force_line(force_line),
    .out_line(out_line), .active_sel(active_sel), .pending(pending),
    .switched(switched), .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int nvec  = 0;
  int nfail = 0;

  // Model: run length of idle cycles (including the current one) and number
  // of cycles the current request has been waiting (including the current one)
  logic [3:0] m_act, m_sw, m_to, m_out, m_pend;
  logic [3:0] n_act, n_sw, n_to;
  int         m_run [4];
  int         m_wait[4];
  int         n_run [4];
  int         n_wait[4];

  task automatic model_reset();
    m_act = '0; m_sw = '0; m_to = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_wait[i] = 0;
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic [3:0] f);
    bit idle, pend, ok, hit, sw;
    in_line0 = a; in_line1 = b; select_line = s; force_line = f;
    m_out  = (m_act & b) | (~m_act & a);
    m_pend = s ^ m_act;
    for (int i = 0; i < 4; i++) begin
      idle      = (a[i] == C_IL[i]) && (b[i] == C_IL[i]);
      pend      = s[i] != m_act[i];
      n_run[i]  = idle ? m_run[i] + 1 : 0;
      n_wait[i] = pend ? m_wait[i] + 1 : 0;
      ok        = idle && (n_run[i] >= C_IDLE);
      hit       = C_TO_EN && pend && (n_wait[i] >= C_TO);
      sw        = pend && (ok || f[i] || hit);
      n_act[i]  = sw ? s[i] : m_act[i];
      n_sw[i]   = sw;
      n_to[i]   = sw && hit && !ok && !f[i];
      if (sw) n_wait[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    m_act = n_act; m_sw = n_sw; m_to = n_to;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = n_run[i]; m_wait[i] = n_wait[i];
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    apply(4'hE, 4'hE, 4'h0, 4'h0);
    #2;
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    in_line0 = 4'hA; in_line1 = 4'h5; select_line = 4'b0110; force_line = 4'h0;
    #2;
    nvec++; if (out_line !== 4'hA) begin nfail++; $display("FAIL reset_out got %h expected %h", out_line, 4'hA); end
    nvec++; if (active_sel !== 4'h0) begin nfail++; $display("FAIL reset_active got %b expected %b", active_sel, 4'h0); end
    nvec++; if (switched !== 4'h0) begin nfail++; $display("FAIL reset_switched got %b expected %b", switched, 4'h0); end
    nvec++; if (timeout !== 4'h0) begin nfail++; $display("FAIL reset_timeout got %b expected %b", timeout, 4'h0); end
    nvec++; if (pending !== 4'b0110) begin nfail++; $display("FAIL reset_pending got %b expected %b", pending, 4'b0110); end
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_idle_switch();
    do_reset();
    for (int k = 0; k < 20; k++) begin apply(4'hF, 4'hF, 4'h0, 4'h0); tick(); end
    apply(4'hF, 4'hF, 4'b0001, 4'h0);
    #1;
    nvec++; if (pending !== 4'b0001) begin nfail++; $display("FAIL idle_pending got %b expected %b", pending, 4'b0001); end
    tick();
    nvec++; if (active_sel !== 4'b0001) begin nfail++; $display("FAIL idle_active got %b expected %b", active_sel, 4'b0001); end
    nvec++; if (switched !== 4'b0001) begin nfail++; $display("FAIL idle_switched got %b expected %b", switched, 4'b0001); end
    apply(4'hF, 4'hE, 4'b0001, 4'h0);
    #1;
    nvec++; if (out_line !== 4'hE) begin nfail++; $display("FAIL idle_out got %h expected %h", out_line, 4'hE); end
    tick();
    nvec++; if (switched !== 4'h0) begin nfail++; $display("FAIL idle_pulse_len got %b expected %b", switched, 4'h0); end
  endtask

  task automatic test_idle_count();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      // 5 busy, a 3-cycle idle gap, then 2 busy
      if (k >= 5 && k < 8) apply(4'hF, 4'hF, 4'b0001, 4'h0);
      else                 apply(4'hE, 4'hF, 4'b0001, 4'h0);
      tick();
      nvec++; if (active_sel !== 4'h0) begin nfail++; $display("FAIL gap_active cycle %0d got %b expected %b", k, active_sel, 4'h0); end
    end
    for (int k = 1; k <= C_IDLE; k++) begin
      apply(4'hF, 4'hF, 4'b0001, 4'h0);
      tick();
      nvec++; if (active_sel !== ((k == C_IDLE) ? 4'b0001 : 4'h0))
        begin nfail++; $display("FAIL count_active idle %0d got %b expected %b", k, active_sel, (k == C_IDLE) ? 4'b0001 : 4'h0); end
      nvec++; if (switched !== ((k == C_IDLE) ? 4'b0001 : 4'h0))
        begin nfail++; $display("FAIL count_switched idle %0d got %b expected %b", k, switched, (k == C_IDLE) ? 4'b0001 : 4'h0); end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k < 5) apply(4'hD, 4'hF, 4'b0010, 4'h0);
      else       apply(4'hF, 4'hF, 4'h0, 4'h0);
      tick();
      nvec++; if (switched !== 4'h0) begin nfail++; $display("FAIL withdraw_switched cycle %0d got %b expected %b", k, switched, 4'h0); end
      nvec++; if (active_sel[1] !== 1'b0) begin nfail++; $display("FAIL withdraw_active cycle %0d got %b expected %b", k, active_sel[1], 1'b0); end
    end
  endtask

  task automatic test_force();
    do_reset();
    for (int k = 0; k < 3; k++) begin apply(4'hB, 4'hF, 4'b0100, 4'h0); tick(); end
    nvec++; if (active_sel !== 4'h0) begin nfail++; $display("FAIL force_wait got %b expected %b", active_sel, 4'h0); end
    apply(4'hB, 4'hF, 4'b0100, 4'b0100);
    #1;
    nvec++; if (pending !== 4'b0100) begin nfail++; $display("FAIL force_pending got %b expected %b", pending, 4'b0100); end
    tick();
    nvec++; if (active_sel !== 4'b0100) begin nfail++; $display("FAIL force_active got %b expected %b", active_sel, 4'b0100); end
    nvec++; if (switched !== 4'b0100) begin nfail++; $display("FAIL force_switched got %b expected %b", switched, 4'b0100); end
    nvec++; if (timeout !== 4'h0) begin nfail++; $display("FAIL force_timeout got %b expected %b", timeout, 4'h0); end
    apply(4'hB, 4'hF, 4'b0100, 4'b0110);
    tick();
    nvec++; if (active_sel !== 4'b0100) begin nfail++; $display("FAIL force_idle_active got %b expected %b", active_sel, 4'b0100); end
    nvec++; if (switched !== 4'h0) begin nfail++; $display("FAIL force_idle_switched got %b expected %b", switched, 4'h0); end
  endtask

  task automatic test_timeout();
    logic [3:0] ea, et;
    do_reset();
    for (int k = 1; k <= (C_TO_EN ? 20 : 100); k++) begin
      apply(4'h7, 4'hF, 4'b1000, 4'h0);
      tick();
      ea = (C_TO_EN && k >= C_TO) ? 4'b1000 : 4'h0;
      et = (C_TO_EN && k == C_TO) ? 4'b1000 : 4'h0;
      nvec++; if (active_sel !== ea) begin nfail++; $display("FAIL to_active cycle %0d got %b expected %b", k, active_sel, ea); end
      nvec++; if (timeout !== et) begin nfail++; $display("FAIL to_pulse cycle %0d got %b expected %b", k, timeout, et); end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int k = 0; k < 4; k++) begin apply(4'hF, 4'hF, 4'b0001, 4'h0); tick(); end
    sys_rst = 1'b1;
    #2;
    nvec++; if (active_sel !== 4'h0) begin nfail++; $display("FAIL midrst_active got %b expected %b", active_sel, 4'h0); end
    model_reset();
    sys_rst = 1'b0;
    for (int k = 1; k <= C_IDLE; k++) begin
      apply(4'hF, 4'hF, 4'b0001, 4'h0);
      tick();
      nvec++; if (active_sel !== ((k == C_IDLE) ? 4'b0001 : 4'h0))
        begin nfail++; $display("FAIL midrst_restart idle %0d got %b expected %b", k, active_sel, (k == C_IDLE) ? 4'b0001 : 4'h0); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r1, r2, r3, r4;
    logic [3:0]  sel;
    do_reset();
    sel = 4'h0;
    for (int k = 0; k < 400; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      if (r3[7:5] == 3'd0) sel = r3[3:0];
      apply(r1[3:0] | r2[3:0] | r4[11:8], r1[7:4] | r2[7:4] | r4[15:12], sel,
            (r3[12:10] == 3'd0) ? r4[3:0] : 4'h0);
      #1;
      nvec++; if (out_line !== m_out) begin nfail++; $display("FAIL rand_out cycle %0d got %h expected %h", k, out_line, m_out); end
      nvec++; if (pending !== m_pend) begin nfail++; $display("FAIL rand_pending cycle %0d got %b expected %b", k, pending, m_pend); end
      tick();
      nvec++; if (active_sel !== m_act) begin nfail++; $display("FAIL rand_active cycle %0d got %b expected %b", k, active_sel, m_act); end
      nvec++; if (switched !== m_sw) begin nfail++; $display("FAIL rand_switched cycle %0d got %b expected %b", k, switched, m_sw); end
      nvec++; if (timeout !== m_to) begin nfail++; $display("FAIL rand_timeout cycle %0d got %b expected %b", k, timeout, m_to); end
    end
  endtask

  initial begin
    sys_rst = 1'b0;
    in_line0 = '0; in_line1 = '0; select_line = '0; force_line = '0;
    model_reset();
    test_reset();
    test_idle_switch();
    test_idle_count();
    test_withdraw();
    test_force();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
